// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states,
// instruction field positions, register indices and the register-bank payload.
package seq_pkg;

   localparam int unsigned INSTR_W = 8;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned REG_W   = 2;
   localparam int unsigned SEL_W   = 2;

   // Opcodes with local meaning; everything else goes through the execute units
   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
   localparam logic [OP_W-1:0] OP_AND  = 4'h7;
   localparam logic [OP_W-1:0] OP_HALT = 4'hF;

   // Instruction register field positions: [7:4] kop, [3:2] dst, [1:0] src/imm
   localparam int unsigned KOP_HI = 7;
   localparam int unsigned KOP_LO = 4;
   localparam int unsigned DST_HI = 3;
   localparam int unsigned DST_LO = 2;
   localparam int unsigned SRC_HI = 1;
   localparam int unsigned SRC_LO = 0;

   localparam logic [SEL_W-1:0] REG_AX = 2'd0;
   localparam logic [SEL_W-1:0] REG_BX = 2'd1;
   localparam logic [SEL_W-1:0] REG_CX = 2'd2;
   localparam logic [SEL_W-1:0] REG_DX = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      HALTED,
      PAUSE
   } state_t;

   // Architectural register file contents as one bus payload
   typedef struct packed {
      logic [REG_W-1:0] dx;
      logic [REG_W-1:0] cx;
      logic [REG_W-1:0] bx;
      logic [REG_W-1:0] ax;
   } regs_t;

endpackage

// File: rtl/instr_sequencer_regbank.sv
// regbank4x2: four 2-bit architectural registers.
// Ports:
//   clk, rst         clock, synchronous active-high clear
//   load, load_val   bulk load of all four registers (execute-unit next state)
//   wr_en, wr_sel,   single-register immediate write
//   wr_data
//   q                current register values
// A bulk load takes priority over the immediate write port.
module regbank4x2
   import seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  regs_t            load_val,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic [REG_W-1:0] wr_data,
   output regs_t            q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (wr_en) begin
         case (wr_sel)
            REG_AX:  q.ax <= wr_data;
            REG_BX:  q.bx <= wr_data;
            REG_CX:  q.cx <= wr_data;
            REG_DX:  q.dx <= wr_data;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch / decode / write-back stage for the four-register
// 2-bit toy datapath. Fetches 8-bit instructions over a req/ack handshake,
// presents the decoded fields for one EXEC cycle, then writes back either
// the LDI immediate or the execute units' next-state values.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin execution at PC 0 from IDLE or HALTED
//   step                      (SINGLE_STEP_EN only) leave PAUSE and fetch
//   imem_req/addr/ack/data    instruction memory handshake
//   kop, reg_dst, reg_src     decoded fields, zero outside EXEC
//   ax..dx / axx..dxx         register values out / next-state values in
//   busy, halted, instr_cnt   status and saturating retired-instruction count
// Build option: define SINGLE_STEP_EN to add the step input and PAUSE state.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned PC_W  = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
`ifdef SINGLE_STEP_EN
   input  logic               step,
`endif
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [OP_W-1:0]    kop,
   output logic [SEL_W-1:0]   reg_dst,
   output logic [SEL_W-1:0]   reg_src,
   output logic [REG_W-1:0]   ax,
   output logic [REG_W-1:0]   bx,
   output logic [REG_W-1:0]   cx,
   output logic [REG_W-1:0]   dx,
   input  logic [REG_W-1:0]   axx,
   input  logic [REG_W-1:0]   bxx,
   input  logic [REG_W-1:0]   cxx,
   input  logic [REG_W-1:0]   dxx,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   instr_cnt
);

   state_t               state_q;
   state_t               state_d;
   logic [PC_W-1:0]      pc_q;
   logic [INSTR_W-1:0]   ir_q;
   logic [OP_W-1:0]      ir_op;

   logic                 ir_load;
   logic                 pc_clear;
   logic                 pc_inc;
   logic                 cnt_inc;
   logic                 bank_load;
   logic                 bank_wr;
   regs_t                load_val;
   regs_t                bank_q;

   assign ir_op     = ir_q[KOP_HI:KOP_LO];
   assign imem_addr = pc_q;

   // Next-state and datapath control decode
   always_comb begin
      state_d   = state_q;
      ir_load   = 1'b0;
      pc_clear  = 1'b0;
      pc_inc    = 1'b0;
      cnt_inc   = 1'b0;
      bank_load = 1'b0;
      bank_wr   = 1'b0;
      case (state_q)
         IDLE, HALTED: begin
            if (start) begin
               state_d  = FETCH;
               pc_clear = 1'b1;
            end
         end
         FETCH: begin
            if (imem_req && imem_ack) begin
               ir_load = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (ir_op == OP_HALT) begin
               state_d = HALTED;
            end else begin
               pc_inc  = 1'b1;
               cnt_inc = 1'b1;
               if (ir_op == OP_LDI) begin
                  bank_wr = 1'b1;
               end else begin
                  bank_load = 1'b1;
               end
`ifdef SINGLE_STEP_EN
               state_d = PAUSE;
`else
               state_d = FETCH;
`endif
            end
         end
`ifdef SINGLE_STEP_EN
         PAUSE: begin
            if (step) begin
               state_d = FETCH;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State, PC, IR, counter and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         instr_cnt <= '0;
         imem_req  <= 1'b0;
         busy      <= 1'b0;
         halted    <= 1'b0;
         kop       <= OP_NOP;
         reg_dst   <= '0;
         reg_src   <= '0;
      end else begin
         state_q  <= state_d;
         if (pc_clear) begin
            pc_q <= '0;
         end else if (pc_inc) begin
            pc_q <= pc_q + PC_W'(1);
         end
         if (ir_load) begin
            ir_q <= imem_data;
         end
         if (cnt_inc && (instr_cnt != '1)) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
         end
         imem_req <= (state_d == FETCH);
         busy     <= (state_d == FETCH) || (state_d == EXEC);
         halted   <= (state_d == HALTED);
         // Decoded fields are valid only for the EXEC cycle that follows the ack
         if (ir_load) begin
            kop     <= imem_data[KOP_HI:KOP_LO];
            reg_dst <= imem_data[DST_HI:DST_LO];
            reg_src <= imem_data[SRC_HI:SRC_LO];
         end else begin
            kop     <= OP_NOP;
            reg_dst <= '0;
            reg_src <= '0;
         end
      end
   end

   always_comb begin
      load_val    = '0;
      load_val.ax = axx;
      load_val.bx = bxx;
      load_val.cx = cxx;
      load_val.dx = dxx;
   end

   regbank4x2 u_bank (
      .clk      (clk),
      .rst      (rst),
      .load     (bank_load),
      .load_val (load_val),
      .wr_en    (bank_wr),
      .wr_sel   (ir_q[DST_HI:DST_LO]),
      .wr_data  (ir_q[SRC_HI:SRC_LO]),
      .q        (bank_q)
   );

   assign ax = bank_q.ax;
   assign bx = bank_q.bx;
   assign cx = bank_q.cx;
   assign dx = bank_q.dx;

endmodule
